alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//   Write-back stage of the 8-bit datapath: the return path from the ALU into the
//   register bank, the opposite direction to the operand read ports.
//   Buffers ALU results (data + destination address) in a small FIFO.
//   Drains them one at a time through a valid/ack register-write port.
//   Publishes a pending-destination mask so the control unit can stall reads of
//   registers that are still being written.
// PARAMETERS
//   DATA_W   8   result / register data width
//   ADDR_W   2   register address width (2**ADDR_W registers)
//   DEPTH    4   result FIFO entries; power of two, >=2
// PORTS
//   clk        in   1                 rising-edge clock
//   reset      in   1                 asynchronous, active-low reset
//   flush      in   1                 sync discard of all queued/in-flight results
//   res_valid  in   1                 ALU result present this cycle
//   res_data   in   DATA_W            ALU result
//   res_dest   in   ADDR_W            destination register
//   res_ready  out  1                 stage can accept a result (= !full)
//   wb_valid   out  1                 register write pending on wb_addr/wb_data
//   wb_addr    out  ADDR_W            register write address
//   wb_data    out  DATA_W            register write data
//   wb_ack     in   1                 register bank took the write this cycle
//   pend_mask  out  2**ADDR_W         bit i = a queued/in-flight write targets reg i
//   zero_flag  out  1                 1 if last completed write had data==0
//   count      out  $clog2(DEPTH)+1   entries in FIFO (excludes output register)
//   drained    out  1                 FIFO empty and !wb_valid
// BEHAVIOUR
//   Reset (reset=0, async): FIFO pointers/count=0, wb_valid=0, wb_addr=0,
//     wb_data=0, zero_flag=0. Hence res_ready=1, pend_mask=0, drained=1.
//   Accept: result taken on a rising edge when res_valid && res_ready.
//     res_ready = (count != DEPTH). It depends only on count: no push when full,
//     even if a pop occurs in the same cycle.
//   Output register free = !wb_valid || wb_ack.
//   Output load on each edge, in priority order:
//     1) FIFO non-empty and output free: head popped into wb_addr/wb_data,
//        wb_valid=1. An accepted result, if any, is written to the FIFO tail.
//     2) FIFO empty, output free, result accepted: result bypasses the FIFO
//        directly into the output register, wb_valid=1 next cycle.
//        Latency is 1 cycle; count stays 0.
//     3) Output free and nothing to load: wb_valid=0. wb_addr/wb_data hold
//        their old values.
//   Hold: while wb_valid && !wb_ack, wb_addr/wb_data are stable (no change).
//   Ordering: writes leave in strict acceptance order. FIFO pointers wrap modulo DEPTH.
//   Throughput: 1 write/cycle sustained when wb_ack is held high.
//   zero_flag: updated only on an edge with wb_valid && wb_ack, to (wb_data==0).
//     Not changed by flush.
//   pend_mask: combinational OR over valid FIFO entries' dest, plus wb_addr
//     when wb_valid. Duplicate destinations are allowed and stay set until
//     the last one drains.
//   flush=1 (sync): next edge sets count=0 and pointers=0, wb_valid=0.
//     A same-cycle res_valid is dropped. A same-cycle wb_ack still updates
//     zero_flag.
//   Reset asserted mid-transfer: all state cleared immediately; pending writes
//     are lost.
//   wb_ack while !wb_valid: ignored.
// TESTING
//   T1 reset: hold reset=0 -> wb_valid=0, res_ready=1, drained=1, pend_mask=0;
//      release, no traffic -> unchanged.
//   T2 bypass: wb_ack=1; push {dest=2,data=8'h05} -> next cycle wb_valid=1,
//      wb_addr=2, wb_data=05, pend_mask=4'b0100, count=0; following cycle
//      drained=1, zero_flag=0.
//   T3 fill/backpressure: wb_ack=0; push 5 results d0..d4 -> d0 in output,
//      count=4, res_ready=0; 6th push ignored. Then wb_ack=1 -> writes d0..d4
//      in order on consecutive cycles.
//   T4 pend_mask: queue dest 1,1,3 with wb_ack=0 -> pend_mask=4'b1010. Ack one
//      -> still 4'b1010. Ack all -> 4'b0000.
//   T5 zero flag: write data 8'h00 acked -> zero_flag=1; then write 8'h03
//      acked -> zero_flag=0.
//   T6 flush/reset mid-op: count=3, wb_valid=1; flush with res_valid=1 ->
//      next cycle count=0, wb_valid=0, drained=1. Repeat using async reset
//      pulse mid-cycle -> outputs cleared before the next edge.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU write-back stage: buffers ALU results in a small FIFO and drains them
// through a valid/ack register-write port, publishing a pending-destination mask.
module alu_writeback #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        res_valid,
    input  logic [DATA_W-1:0]           res_data,
    input  logic [ADDR_W-1:0]           res_dest,
    output logic                        res_ready,
    output logic                        wb_valid,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic [DATA_W-1:0]           wb_data,
    input  logic                        wb_ack,
    output logic [(2**ADDR_W)-1:0]      pend_mask,
    output logic                        zero_flag,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        drained
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2**ADDR_W;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_dest [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              fifo_empty;
    logic              out_free;
    logic              accept;
    logic              pop;
    logic              bypass;
    logic              push_fifo;
    logic [CNT_W-1:0]  count_next;

    // Handshake decode: pop has priority over bypass into the output register
    always_comb begin
        fifo_empty = (count == '0);
        out_free   = !wb_valid || wb_ack;
        res_ready  = (count != CNT_W'(DEPTH));
        accept     = res_valid && res_ready && !flush;
        pop        = !fifo_empty && out_free;
        bypass     = fifo_empty && out_free && accept;
        push_fifo  = accept && !bypass;
        count_next = count + CNT_W'(push_fifo) - CNT_W'(pop);
        drained    = fifo_empty && !wb_valid;
    end

    // Pending-destination mask over live FIFO entries plus the output register
    always_comb begin
        logic [PTR_W-1:0] idx;
        pend_mask = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = PTR_W'(rd_ptr + PTR_W'(k));
            if (CNT_W'(k) < count) begin
                pend_mask[mem_dest[idx]] = 1'b1;
            end
        end
        if (wb_valid) begin
            pend_mask[wb_addr] = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count qualifies them
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            mem_data[wr_ptr] <= res_data;
            mem_dest[wr_ptr] <= res_dest;
        end
    end

    // Pointers, count, output register and zero flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            zero_flag <= 1'b0;
        end else begin
            if (wb_valid && wb_ack) begin
                zero_flag <= (wb_data == '0);
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                wb_valid <= 1'b0;
            end else begin
                count <= count_next;
                if (push_fifo) begin
                    wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
                end
                if (pop) begin
                    rd_ptr   <= PTR_W'(rd_ptr + PTR_W'(1));
                    wb_valid <= 1'b1;
                    wb_addr  <= mem_dest[rd_ptr];
                    wb_data  <= mem_data[rd_ptr];
                end else if (bypass) begin
                    wb_valid <= 1'b1;
                    wb_addr  <= res_dest;
                    wb_data  <= res_data;
                end else if (out_free) begin
                    wb_valid <= 1'b0;
                end
            end
        end
    end

    // NREG documents the mask width; referenced to keep the intent explicit
    logic unused_nreg;
    assign unused_nreg = (NREG == (2**ADDR_W));

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for the ALU write-back stage.
module tb_alu_writeback;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       res_valid;
    logic [7:0] res_data;
    logic [1:0] res_dest;
    logic       res_ready;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       wb_ack;
    logic [3:0] pend_mask;
    logic       zero_flag;
    logic [2:0] count;
    logic       drained;

    int checks = 0;
    int errors = 0;

    alu_writeback #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_dest  (res_dest),
        .res_ready (res_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ack    (wb_ack),
        .pend_mask (pend_mask),
        .zero_flag (zero_flag),
        .count     (count),
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] dest, input logic [7:0] data);
        res_valid = 1'b1;
        res_dest  = dest;
        res_data  = data;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; res_valid = 1'b0;
        res_data = 8'h00; res_dest = 2'd0; wb_ack = 1'b0;

        // T1 reset
        step(); step();
        chk("t1_wb_valid",  32'(wb_valid), 32'd0);
        chk("t1_res_ready", 32'(res_ready), 32'd1);
        chk("t1_drained",   32'(drained), 32'd1);
        chk("t1_pend",      32'(pend_mask), 32'h0);
        chk("t1_count",     32'(count), 32'd0);
        chk("t1_zero",      32'(zero_flag), 32'd0);
        reset = 1'b1;
        step(); step();
        chk("t1_idle_valid",   32'(wb_valid), 32'd0);
        chk("t1_idle_drained", 32'(drained), 32'd1);
        chk("t1_idle_pend",    32'(pend_mask), 32'h0);

        // T2 bypass
        wb_ack = 1'b1;
        push(2'd2, 8'h05);
        chk("t2_valid", 32'(wb_valid), 32'd1);
        chk("t2_addr",  32'(wb_addr), 32'd2);
        chk("t2_data",  32'(wb_data), 32'h05);
        chk("t2_pend",  32'(pend_mask), 32'h4);
        chk("t2_count", 32'(count), 32'd0);
        step();
        chk("t2_drained", 32'(drained), 32'd1);
        chk("t2_zero",    32'(zero_flag), 32'd0);

        // T3 fill / backpressure
        wb_ack = 1'b0;
        for (int i = 0; i < 5; i++) push(2'(i), 8'h10 + 8'(i));
        chk("t3_count",  32'(count), 32'd4);
        chk("t3_ready",  32'(res_ready), 32'd0);
        chk("t3_head",   32'(wb_data), 32'h10);
        push(2'd3, 8'hEE);
        chk("t3_full_count", 32'(count), 32'd4);
        chk("t3_full_hold",  32'(wb_data), 32'h10);
        wb_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_drain_valid", 32'(wb_valid), 32'd1);
            chk("t3_drain_data",  32'(wb_data), 32'h10 + 32'(i));
            chk("t3_drain_addr",  32'(wb_addr), 32'(i % 4));
            step();
        end
        chk("t3_end_valid",   32'(wb_valid), 32'd0);
        chk("t3_end_drained", 32'(drained), 32'd1);

        // T4 pend_mask with duplicate destinations
        wb_ack = 1'b0;
        push(2'd1, 8'h21);
        push(2'd1, 8'h22);
        push(2'd3, 8'h23);
        chk("t4_pend_all", 32'(pend_mask), 32'hA);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        chk("t4_pend_one", 32'(pend_mask), 32'hA);
        chk("t4_data_one", 32'(wb_data), 32'h22);
        wb_ack = 1'b1;
        step();
        chk("t4_pend_two", 32'(pend_mask), 32'h8);
        step();
        chk("t4_pend_none", 32'(pend_mask), 32'h0);
        chk("t4_drained",   32'(drained), 32'd1);

        // T5 zero flag
        push(2'd0, 8'h00);
        step();
        chk("t5_zero_set", 32'(zero_flag), 32'd1);
        push(2'd0, 8'h03);
        step();
        chk("t5_zero_clr", 32'(zero_flag), 32'd0);

        // T6 flush mid-operation
        wb_ack = 1'b0;
        for (int i = 0; i < 4; i++) push(2'(i), 8'h40 + 8'(i));
        chk("t6_pre_count", 32'(count), 32'd3);
        chk("t6_pre_valid", 32'(wb_valid), 32'd1);
        flush = 1'b1;
        push(2'd2, 8'h77);
        flush = 1'b0;
        chk("t6_fl_count",   32'(count), 32'd0);
        chk("t6_fl_valid",   32'(wb_valid), 32'd0);
        chk("t6_fl_drained", 32'(drained), 32'd1);
        chk("t6_fl_pend",    32'(pend_mask), 32'h0);
        step();
        chk("t6_fl_drop", 32'(wb_valid), 32'd0);

        // T6 async reset mid-cycle
        for (int i = 0; i < 4; i++) push(2'(i), 8'h50 + 8'(i));
        chk("t6_re_pre_count", 32'(count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid",   32'(wb_valid), 32'd0);
        chk("t6_rst_count",   32'(count), 32'd0);
        chk("t6_rst_drained", 32'(drained), 32'd1);
        chk("t6_rst_ready",   32'(res_ready), 32'd1);
        chk("t6_rst_data",    32'(wb_data), 32'h0);
        reset = 1'b1;
        step();
        chk("t6_post_valid", 32'(wb_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
